// File: rtl/ysyx_24100027_ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one read at a time, hands pc/inst pairs to the core.
// Optional performance counters are enabled with `define YSYX_24100027_IFU_PERF_EN.
module ysyx_24100027_ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            resp_valid,
    input  logic [XLEN-1:0] resp_data,
    input  logic            resp_err,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_inst,
    output logic            out_fault,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
`ifdef YSYX_24100027_IFU_PERF_EN
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_stall_cnt,
`endif
    output logic [1:0]      dbg_state
);

    // Handshake rule for both channels: a transfer happens in any cycle where
    // valid && ready are both high at the rising edge; valid never depends on ready.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [XLEN-1:0]   pc, pc_n;
    logic              drop, drop_n;
    logic              out_valid_q, out_valid_n;
    logic [XLEN-1:0]   out_pc_n, out_inst_n;
    logic              out_fault_n;
    logic [XLEN-1:0]   redirect_target;
    logic              req_hs;

    assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
    assign req_valid       = (state == S_REQ) && !rst;
    assign req_addr        = pc;
    assign req_hs          = req_valid && req_ready;
    assign out_valid       = out_valid_q;
    assign dbg_state       = state;

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        drop_n      = drop;
        out_valid_n = out_valid_q;
        out_pc_n    = out_pc;
        out_inst_n  = out_inst;
        out_fault_n = out_fault;
        case (state)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_n = redirect_target;
                    // The old address was already accepted; its beat must be thrown away.
                    if (req_hs) begin
                        state_n = S_WAIT;
                        drop_n  = 1'b1;
                    end
                end else if (req_hs) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_n = redirect_target;
                    if (resp_valid) begin
                        state_n = S_REQ;
                        drop_n  = 1'b0;
                    end else begin
                        drop_n  = 1'b1;
                    end
                end else if (resp_valid) begin
                    if (drop) begin
                        state_n = S_REQ;
                        drop_n  = 1'b0;
                    end else begin
                        state_n     = S_OUT;
                        out_valid_n = 1'b1;
                        out_pc_n    = pc;
                        out_inst_n  = resp_data;
                        out_fault_n = resp_err;
                    end
                end
            end
            S_OUT: begin
                if (redirect_valid) begin
                    pc_n        = redirect_target;
                    state_n     = S_REQ;
                    out_valid_n = 1'b0;
                end else if (out_ready) begin
                    pc_n        = pc + 32'd4;
                    state_n     = S_REQ;
                    out_valid_n = 1'b0;
                end
            end
            default: begin
                state_n     = S_REQ;
                out_valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            drop        <= 1'b0;
            out_valid_q <= 1'b0;
            out_pc      <= '0;
            out_inst    <= '0;
            out_fault   <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            drop        <= drop_n;
            out_valid_q <= out_valid_n;
            out_pc      <= out_pc_n;
            out_inst    <= out_inst_n;
            out_fault   <= out_fault_n;
        end
    end

`ifdef YSYX_24100027_IFU_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (out_valid && out_ready && !redirect_valid)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if ((state != S_OUT) || !out_ready)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_24100027_ifu_fetch.sv
// Directed bench for ysyx_24100027_ifu_fetch: sequential fetch, stall, redirects, wrap, fault, reset.
module tb_ysyx_24100027_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        resp_valid, resp_err;
    logic [31:0] resp_data;
    logic        out_valid, out_ready, out_fault;
    logic [31:0] out_pc, out_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [1:0]  dbg_state;
`ifdef YSYX_24100027_IFU_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_24100027_ifu_fetch dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_inst(out_inst), .out_fault(out_fault),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
`ifdef YSYX_24100027_IFU_PERF_EN
        .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
        .dbg_state(dbg_state)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        resp_data      = '0;
        resp_err       = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
    endtask

    task automatic drive_resp(input logic [31:0] data, input logic err);
        resp_valid = 1'b1;
        resp_data  = data;
        resp_err   = err;
        tick();
        resp_valid = 1'b0;
        resp_err   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        tick();
        tick();
        n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b expected 0", req_valid); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL rst_out_pc: got %h expected 0", out_pc); end
        n_checks++; if (out_inst !== 32'h0) begin n_fail++; $display("FAIL rst_out_inst: got %h expected 0", out_inst); end
        n_checks++; if (out_fault !== 1'b0) begin n_fail++; $display("FAIL rst_out_fault: got %b expected 0", out_fault); end
        n_checks++; if (req_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL rst_pc: got %h expected 80000000", req_addr); end
        n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d expected 0", dbg_state); end
`ifdef YSYX_24100027_IFU_PERF_EN
        n_checks++; if (perf_fetch_cnt !== 32'h0) begin n_fail++; $display("FAIL rst_perf_fetch: got %h expected 0", perf_fetch_cnt); end
`endif
        rst = 1'b0;
        #1;
        n_checks++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL post_rst_req_valid: got %b expected 1", req_valid); end
    endtask

    task automatic test_sequential();
        logic [31:0] words [3];
        words[0] = 32'h0000_0413;
        words[1] = 32'h0010_0493;
        words[2] = 32'h0084_0533;
        req_ready = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_0000 + 32'(4 * k)) begin n_fail++; $display("FAIL seq_req[%0d]: got v=%b a=%h expected v=1 a=%h", k, req_valid, req_addr, 32'h8000_0000 + 32'(4 * k)); end
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL seq_out_idle[%0d]: got %b expected 0", k, out_valid); end
            tick();
            n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL seq_wait_req[%0d]: got %b expected 0", k, req_valid); end
            drive_resp(words[k], 1'b0);
            n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h8000_0000 + 32'(4 * k) || out_inst !== words[k]) begin n_fail++; $display("FAIL seq_out[%0d]: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h", k, out_valid, out_pc, out_inst, 32'h8000_0000 + 32'(4 * k), words[k]); end
            tick();
        end
    endtask

    task automatic test_stall();
        tick();
        drive_resp(32'hDEAD_BEEF, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h8000_000C || out_inst !== 32'hDEAD_BEEF || req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_hold[%0d]: got v=%b pc=%h inst=%h rv=%b expected v=1 pc=8000000c inst=deadbeef rv=0", i, out_valid, out_pc, out_inst, req_valid); end
            tick();
        end
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h8000_0010) begin n_fail++; $display("FAIL stall_release: got v=%b rv=%b a=%h expected v=0 rv=1 a=80000010", out_valid, req_valid, req_addr); end
    endtask

    task automatic test_redirect_out();
        tick();
        drive_resp(32'h0000_0013, 1'b0);
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h8000_0010) begin n_fail++; $display("FAIL rdo_out: got v=%b pc=%h expected v=1 pc=80000010", out_valid, out_pc); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || dbg_state !== 2'd0 || req_addr !== 32'h8000_0100) begin n_fail++; $display("FAIL rdo_target: got v=%b st=%0d a=%h expected v=0 st=0 a=80000100", out_valid, dbg_state, req_addr); end
    endtask

    task automatic test_redirect_wait();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_1002;
        tick();
        redirect_valid = 1'b0;
        n_checks++; if (req_valid !== 1'b0 || dbg_state !== 2'd1) begin n_fail++; $display("FAIL rdw_wait: got rv=%b st=%0d expected rv=0 st=1", req_valid, dbg_state); end
        drive_resp(32'hBAD0_BAD0, 1'b0);
        n_checks++; if (out_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 32'h8000_1000) begin n_fail++; $display("FAIL rdw_drop: got v=%b rv=%b a=%h expected v=0 rv=1 a=80001000", out_valid, req_valid, req_addr); end
        tick();
        drive_resp(32'h1234_5678, 1'b0);
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h8000_1000 || out_inst !== 32'h1234_5678) begin n_fail++; $display("FAIL rdw_resume: got v=%b pc=%h inst=%h expected v=1 pc=80001000 inst=12345678", out_valid, out_pc, out_inst); end
        tick();
        n_checks++; if (req_addr !== 32'h8000_1004) begin n_fail++; $display("FAIL rdw_next: got %h expected 80001004", req_addr); end
    endtask

    task automatic test_redirect_corners();
        // Redirect coinciding with the response beat
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_2000;
        drive_resp(32'hBAD1_BAD1, 1'b0);
        redirect_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || dbg_state !== 2'd0 || req_addr !== 32'h8000_2000) begin n_fail++; $display("FAIL rdc_resp: got v=%b st=%0d a=%h expected v=0 st=0 a=80002000", out_valid, dbg_state, req_addr); end
        // Redirect coinciding with request acceptance
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_3000;
        tick();
        redirect_valid = 1'b0;
        n_checks++; if (dbg_state !== 2'd1 || req_valid !== 1'b0) begin n_fail++; $display("FAIL rdc_hs_wait: got st=%0d rv=%b expected st=1 rv=0", dbg_state, req_valid); end
        drive_resp(32'hBAD2_BAD2, 1'b0);
        n_checks++; if (out_valid !== 1'b0 || req_addr !== 32'h8000_3000) begin n_fail++; $display("FAIL rdc_hs_drop: got v=%b a=%h expected v=0 a=80003000", out_valid, req_addr); end
        // Redirect while the request is not accepted
        req_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_400B;
        tick();
        redirect_valid = 1'b0;
        n_checks++; if (dbg_state !== 2'd0 || req_valid !== 1'b1 || req_addr !== 32'h8000_4008) begin n_fail++; $display("FAIL rdc_nohs: got st=%0d rv=%b a=%h expected st=0 rv=1 a=80004008", dbg_state, req_valid, req_addr); end
    endtask

    task automatic test_wrap_fault();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        n_checks++; if (req_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_req: got %h expected fffffffc", req_addr); end
        req_ready = 1'b1;
        tick();
        drive_resp(32'h0010_0073, 1'b1);
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC || out_inst !== 32'h0010_0073 || out_fault !== 1'b1) begin n_fail++; $display("FAIL fault_out: got v=%b pc=%h inst=%h f=%b expected v=1 pc=fffffffc inst=00100073 f=1", out_valid, out_pc, out_inst, out_fault); end
        tick();
        n_checks++; if (req_valid !== 1'b1 || req_addr !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_next: got rv=%b a=%h expected rv=1 a=00000000", req_valid, req_addr); end
        tick();
        drive_resp(32'h0000_0093, 1'b0);
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_fault !== 1'b0) begin n_fail++; $display("FAIL fault_continue: got v=%b pc=%h f=%b expected v=1 pc=0 f=0", out_valid, out_pc, out_fault); end
        tick();
        n_checks++; if (req_addr !== 32'h0000_0004) begin n_fail++; $display("FAIL wrap_after: got %h expected 00000004", req_addr); end
    endtask

    task automatic test_reset_mid();
        tick();
        n_checks++; if (dbg_state !== 2'd1) begin n_fail++; $display("FAIL rmid_pre: got st=%0d expected 1", dbg_state); end
        rst = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0 || req_valid !== 1'b0 || req_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL rmid_rst: got v=%b rv=%b a=%h expected v=0 rv=0 a=80000000", out_valid, req_valid, req_addr); end
        rst       = 1'b0;
        req_ready = 1'b0;
        // Stale beat from the abandoned request lands in the first S_REQ cycle
        resp_valid = 1'b1;
        resp_data  = 32'hBAD3_BAD3;
        #1;
        n_checks++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL rmid_release: got rv=%b a=%h expected rv=1 a=80000000", req_valid, req_addr); end
        tick();
        resp_valid = 1'b0;
        n_checks++; if (dbg_state !== 2'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_stale: got st=%0d v=%b expected st=0 v=0", dbg_state, out_valid); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_out();
        test_redirect_wait();
        test_redirect_corners();
        test_wrap_fault();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
